// File: rtl/fp_add_arb_pkg.sv
// Shared types and constants for the two-requester FP-add datapath arbiter.
package fp_add_arb_pkg;

    localparam int FP_WIDTH          = 32;
    localparam int DEF_SETTLE_CYCLES = 2;
    // Settle counter holds SETTLE_CYCLES-1, so 4 bits cover the 1..15 range.
    localparam int SETTLE_CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; purely combinational, zero latency.
// No backpressure of its own: the caller decides whether a grant is consumed.
module rr_arb2
    import fp_add_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last_grant,
    output logic       grant_valid,
    output req_id_t    grant_id
);

    always_comb begin
        grant_valid = |valid;
        grant_id    = 1'b0;
        case (valid)
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one combinational FP-add datapath between two requesters, round-robin.
// Result is registered SETTLE_CYCLES edges after accept and held until rsp_ready.
module fp_add_arbiter
    import fp_add_arb_pkg::*;
#(
    parameter int WIDTH         = FP_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    input  logic [WIDTH-1:0] dp_sum,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [SETTLE_CNT_W-1:0] CNT_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]        dp_a_q, dp_a_d, dp_b_q, dp_b_d;
    logic [WIDTH-1:0]        rsp_sum_q, rsp_sum_d;
    req_id_t                 rsp_id_q, rsp_id_d, cur_id_q, cur_id_d;
    req_id_t                 last_grant_q, last_grant_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]        op_count_q, op_count_d;

    logic    grant_valid;
    req_id_t grant_id;

    rr_arb2 u_rr_arb2 (
        .valid       ({req1_valid, req0_valid}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dp_a_d       = dp_a_q;
        dp_b_d       = dp_b_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_id_d     = rsp_id_q;
        cur_id_d     = cur_id_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        op_count_d   = op_count_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                req0_ready = grant_valid && (grant_id == 1'b0);
                req1_ready = grant_valid && (grant_id == 1'b1);
                // A grant always lands on a valid requester, so it is the accept.
                if (grant_valid) begin
                    dp_a_d   = grant_id ? req1_a : req0_a;
                    dp_b_d   = grant_id ? req1_b : req0_b;
                    cur_id_d = grant_id;
                    cnt_d    = CNT_LOAD;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    rsp_sum_d   = dp_sum;
                    rsp_id_d    = cur_id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - SETTLE_CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    op_count_d   = op_count_q + CNT_W'(1);
                    last_grant_d = rsp_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dp_a_q       <= '0;
            dp_b_q       <= '0;
            rsp_sum_q    <= '0;
            rsp_id_q     <= 1'b0;
            cur_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dp_a_q       <= dp_a_d;
            dp_b_q       <= dp_b_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_id_q     <= rsp_id_d;
            cur_id_q     <= cur_id_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            op_count_q   <= op_count_d;
        end
    end

    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_valid = rsp_valid_q;
    assign op_count  = op_count_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: transaction model plus directed literal checks.
module tb_fp_add_arbiter;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] dp_a, dp_b, dp_sum, rsp_sum;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [15:0] op_count;

    // Second instance: one-edge settle and a 4-bit counter so the wrap is cheap.
    logic        s_req0_valid, s_req0_ready, s_req1_valid, s_req1_ready;
    logic [31:0] s_req0_a, s_req0_b, s_req1_a, s_req1_b;
    logic [31:0] s_dp_a, s_dp_b, s_dp_sum, s_rsp_sum;
    logic        s_rsp_valid, s_rsp_ready, s_rsp_id, s_busy;
    logic [3:0]  s_op_count;

    // Stand-in datapath: exact IEEE sums for the named pairs, a fixed mix otherwise.
    function automatic logic [31:0] dp_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
            {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
            {32'hC000_0000, 32'h4000_0000}: return 32'h0000_0000;
            default: return (a ^ {b[15:0], b[31:16]}) + 32'h1234_5677;
        endcase
    endfunction

    assign dp_sum   = dp_model(dp_a, dp_b);
    assign s_dp_sum = dp_model(s_dp_a, s_dp_b);

    fp_add_arbiter #(.WIDTH(32), .SETTLE_CYCLES(S), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .dp_a(dp_a), .dp_b(dp_b), .dp_sum(dp_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .busy(busy), .op_count(op_count)
    );

    fp_add_arbiter #(.WIDTH(32), .SETTLE_CYCLES(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_a(s_req0_a), .req0_b(s_req0_b),
        .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_a(s_req1_a), .req1_b(s_req1_b),
        .dp_a(s_dp_a), .dp_b(s_dp_b), .dp_sum(s_dp_sum),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id), .rsp_sum(s_rsp_sum),
        .busy(s_busy), .op_count(s_op_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s wait bound expired", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction model: an accepted pair yields a response S edges later,
    // held until the consumer takes it; ties go to whoever was not served last.
    logic        m_inflight, m_rv, m_id, m_last;
    int          m_wait;
    logic [31:0] m_a, m_b, m_sum;
    logic [15:0] m_cnt;
    logic        m_busy, g_vld, g_id;
    logic        acc0, acc1;
    int          acc_log[$];

    always @(negedge clk) begin
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!rst_n) begin
            m_inflight = 1'b0; m_rv = 1'b0; m_id = 1'b0; m_last = 1'b1;
            m_wait = 0; m_a = '0; m_b = '0; m_sum = '0; m_cnt = '0;
        end else begin
            m_busy = m_inflight || m_rv;
            g_vld  = req0_valid || req1_valid;
            g_id   = (req0_valid && req1_valid) ? ~m_last : req1_valid;
            check("m_busy", busy, m_busy);
            check("m_req0_ready", req0_ready, !m_busy && g_vld && !g_id);
            check("m_req1_ready", req1_ready, !m_busy && g_vld && g_id);
            check("m_rsp_valid", rsp_valid, m_rv);
            if (m_rv) begin
                check("m_rsp_id", rsp_id, m_id);
                check("m_rsp_sum", rsp_sum, m_sum);
            end
            check("m_dp_a", dp_a, m_a);
            check("m_dp_b", dp_b, m_b);
            check("m_op_count", op_count, m_cnt);
            if (!m_busy) begin
                if (g_vld) begin
                    m_a = g_id ? req1_a : req0_a;
                    m_b = g_id ? req1_b : req0_b;
                    m_id = g_id;
                    m_inflight = 1'b1;
                    m_wait = S;
                    acc0 = !g_id;
                    acc1 = g_id;
                    acc_log.push_back(int'(g_id));
                end
            end else if (m_inflight) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_inflight = 1'b0;
                    m_rv = 1'b1;
                    m_sum = dp_model(m_a, m_b);
                end
            end else if (rsp_ready) begin
                m_rv = 1'b0;
                m_cnt++;
                m_last = m_id;
            end
        end
    end

    task automatic pick(output logic [31:0] a, output logic [31:0] b);
        case ($urandom_range(0, 3))
            0: begin a = 32'h3F80_0000; b = 32'h4000_0000; end
            1: begin a = 32'h4000_0000; b = 32'h4000_0000; end
            2: begin a = 32'hC000_0000; b = 32'h4000_0000; end
            default: begin a = $urandom; b = $urandom; end
        endcase
    endtask

    int lat, guard;

    initial begin
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        s_req0_valid = 0; s_req1_valid = 0; s_rsp_ready = 1;
        s_req0_a = 0; s_req0_b = 0; s_req1_a = 0; s_req1_b = 0;

        repeat (2) step();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);
        check("rst_dp_a", dp_a, 0);
        check("rst_rsp_sum", rsp_sum, 0);
        rst_n = 1;
        step();

        // Single op from requester 0.
        req0_valid = 1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000;
        #1 check("single_ready", req0_ready, 1);
        step();
        req0_valid = 0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin step(); lat++; end
        check("single_latency", lat, 2);
        check("single_id", rsp_id, 0);
        check("single_sum", rsp_sum, 32'h4040_0000);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        check("single_count", op_count, 1);

        // Cancellation operands under 5 cycles of backpressure.
        req1_valid = 1; req1_a = 32'hC000_0000; req1_b = 32'h4000_0000;
        step();
        req1_valid = 0;
        guard = 0;
        while (!rsp_valid && guard < 20) begin step(); guard++; end
        if (guard >= 20) timeout_fail("cancel_rsp");
        req0_valid = 1; req0_a = 32'h4000_0000; req0_b = 32'h4000_0000;
        repeat (5) step();
        check("bp_valid", rsp_valid, 1);
        check("bp_sum", rsp_sum, 32'h0000_0000);
        check("bp_id", rsp_id, 1);
        check("bp_busy", busy, 1);
        check("bp_req0_ready", req0_ready, 0);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        check("bp_done_valid", rsp_valid, 0);
        check("bp_done_count", op_count, 2);
        check("post_resp_ready", req0_ready, 1);
        step();

        // Asynchronous reset while the next op is settling.
        #2 rst_n = 0;
        #1;
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_op_count", op_count, 0);
        req0_valid = 0;
        step();
        rst_n = 1;
        repeat (4) step();
        check("arst_no_rsp", rsp_valid, 0);

        // Tie: both continuously valid after reset.
        rsp_ready = 1;
        req0_valid = 1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000;
        req1_valid = 1; req1_a = 32'h4000_0000; req1_b = 32'h4000_0000;
        acc_log.delete();
        guard = 0;
        while (acc_log.size() < 4 && guard < 100) begin step(); guard++; end
        if (guard >= 100) timeout_fail("tie_accepts");
        else begin
            check("tie_order0", acc_log[0], 0);
            check("tie_order1", acc_log[1], 1);
            check("tie_order2", acc_log[2], 0);
            check("tie_order3", acc_log[3], 1);
        end
        req0_valid = 0; req1_valid = 0;

        // Randomised traffic with drops and backpressure.
        for (int c = 0; c < 3000; c++) begin
            step();
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (req0_valid && acc0) req0_valid = 0;
            if (req1_valid && acc1) req1_valid = 0;
            if (!req0_valid) begin
                if ($urandom_range(0, 2) == 0) begin req0_valid = 1; pick(req0_a, req0_b); end
            end else if ($urandom_range(0, 19) == 0) req0_valid = 0;
            if (!req1_valid) begin
                if ($urandom_range(0, 2) == 0) begin req1_valid = 1; pick(req1_a, req1_b); end
            end else if ($urandom_range(0, 19) == 0) req1_valid = 0;
        end
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        guard = 0;
        while ((busy || rsp_valid) && guard < 50) begin step(); guard++; end
        if (guard >= 50) timeout_fail("drain");

        // One-edge settle instance: latency and 4-bit counter wrap.
        for (int k = 0; k < 20; k++) begin
            s_req0_valid = 1; s_req0_a = 32'(k); s_req0_b = 32'h4000_0000;
            #1 check("s1_ready", s_req0_ready, 1);
            step();
            s_req0_valid = 0;
            lat = 0;
            while (!s_rsp_valid && lat < 10) begin step(); lat++; end
            check("s1_latency", lat, 1);
            check("s1_sum", s_rsp_sum, dp_model(32'(k), 32'h4000_0000));
            check("s1_id", s_rsp_id, 0);
            step();
            if (k == 15) check("s1_wrap", s_op_count, 0);
        end
        check("s1_final_count", s_op_count, 4);
        check("s1_idle", s_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
